// File: rtl/md5_search_ctrl.sv
// rtl/md5_search_ctrl.sv - MD5 candidate search sequencer for one chunk-cruncher
//
// Walks the candidate range [cfg_first..cfg_last] (inclusive, wrapping through
// 0xFFFFFFFF -> 0). For each candidate it loads a padded single-block message
// into the cruncher message RAM, resets and starts the cruncher, waits for
// cr_done and compares the digest against the latched target.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   cfg_start, cfg_abort       start pulse (IDLE only), abort pulse (wins)
//   cfg_first/last/target      search range and target digest {d,c,b,a}
//   busy, found, exhausted     status; found/exhausted are sticky
//   match_value, cand_count    matching candidate, candidates checked
//   msg_we/waddr/wdata         message RAM write port
//   cr_reset, cr_start         cruncher reset (combinational) and start pulse
//   cr_done, cr_digest         cruncher completion level and digest
module md5_search_ctrl #(
  parameter int MSG_LEN_BITS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_start,
  input  logic         cfg_abort,
  input  logic [31:0]  cfg_first,
  input  logic [31:0]  cfg_last,
  input  logic [127:0] cfg_target,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic [31:0]  match_value,
  output logic [31:0]  cand_count,
  output logic         msg_we,
  output logic [3:0]   msg_waddr,
  output logic [31:0]  msg_wdata,
  output logic         cr_reset,
  output logic         cr_start,
  input  logic         cr_done,
  input  logic [127:0] cr_digest
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CRST, S_CSTART, S_WAIT, S_CHECK
  } state_t;

  state_t        state, state_n;
  logic [3:0]    w, w_n;
  logic [31:0]   cand, cand_n;
  logic [31:0]   last_q;
  logic [127:0]  target_q, digest_q;
  logic          accept, abort_cycle, hit;

  // Little-endian MD5 padding of a 4-byte message into one 512-bit block.
  function automatic logic [31:0] word_of(input logic [3:0] idx, input logic [31:0] c);
    case (idx)
      4'd0:    word_of = c;
      4'd1:    word_of = 32'h0000_0080;
      4'd14:   word_of = 32'(MSG_LEN_BITS);
      default: word_of = 32'h0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    w_n         = w;
    cand_n      = cand;
    accept      = 1'b0;
    abort_cycle = 1'b0;
    hit         = (digest_q == target_q);
    case (state)
      S_IDLE: begin
        if (cfg_start && !cfg_abort) begin
          accept  = 1'b1;
          cand_n  = cfg_first;
          w_n     = 4'd0;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w == 4'd15) state_n = S_CRST;
        else            w_n     = w + 4'd1;
      end
      S_CRST:   state_n = S_CSTART;
      S_CSTART: state_n = S_WAIT;
      S_WAIT:   if (cr_done) state_n = S_CHECK;
      S_CHECK: begin
        if (hit || cand == last_q) begin
          state_n = S_IDLE;
        end else begin
          cand_n  = cand + 32'd1;
          w_n     = 4'd0;
          state_n = S_LOAD;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Abort overrides whatever the state wanted to do this cycle.
    if (state != S_IDLE && cfg_abort) begin
      abort_cycle = 1'b1;
      state_n     = S_IDLE;
      cand_n      = cand;
    end
  end

  // The cruncher keeps its chaining values between runs, so it is reset
  // ahead of every candidate and whenever a search is torn down.
  assign cr_reset = reset | (state == S_CRST) | abort_cycle;

  always_ff @(posedge clk) begin
    if (reset) begin
      w           <= 4'd0;
      cand        <= 32'd0;
      last_q      <= 32'd0;
      target_q    <= 128'd0;
      digest_q    <= 128'd0;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      match_value <= 32'd0;
      cand_count  <= 32'd0;
      msg_we      <= 1'b0;
      msg_waddr   <= 4'd0;
      msg_wdata   <= 32'd0;
      cr_start    <= 1'b0;
    end else begin
      w        <= w_n;
      cand     <= cand_n;
      // Outputs are registered from the next state so they line up with it.
      busy     <= (state_n != S_IDLE);
      msg_we   <= (state_n == S_LOAD);
      cr_start <= (state_n == S_CSTART);
      if (state_n == S_LOAD) begin
        msg_waddr <= w_n;
        msg_wdata <= word_of(w_n, cand_n);
      end
      if (accept) begin
        last_q     <= cfg_last;
        target_q   <= cfg_target;
        found      <= 1'b0;
        exhausted  <= 1'b0;
        cand_count <= 32'd0;
      end
      if (state == S_WAIT && cr_done) digest_q <= cr_digest;
      if (state == S_CHECK && !abort_cycle) begin
        cand_count <= cand_count + 32'd1;
        if (hit) begin
          found       <= 1'b1;
          match_value <= cand;
        end else if (cand == last_q) begin
          exhausted <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_md5_search_ctrl.sv
// tb/tb_md5_search_ctrl.sv - self-checking bench for md5_search_ctrl with stub cruncher
module tb_md5_search_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_start, cfg_abort;
  logic [31:0]  cfg_first, cfg_last;
  logic [127:0] cfg_target;
  logic         busy, found, exhausted;
  logic [31:0]  match_value, cand_count;
  logic         msg_we;
  logic [3:0]   msg_waddr;
  logic [31:0]  msg_wdata;
  logic         cr_reset, cr_start, cr_done;
  logic [127:0] cr_digest;

  always #5 clk = ~clk;

  md5_search_ctrl #(.MSG_LEN_BITS(32)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_first(cfg_first), .cfg_last(cfg_last), .cfg_target(cfg_target),
    .busy(busy), .found(found), .exhausted(exhausted),
    .match_value(match_value), .cand_count(cand_count),
    .msg_we(msg_we), .msg_waddr(msg_waddr), .msg_wdata(msg_wdata),
    .cr_reset(cr_reset), .cr_start(cr_start),
    .cr_done(cr_done), .cr_digest(cr_digest)
  );

  // Stub cruncher: digest = {4{word 0}}, done 10 cycles after cr_start.
  logic [31:0] ram [16];
  int          stub_cnt;
  logic        stub_done;

  always @(posedge clk) begin
    if (msg_we) ram[msg_waddr] <= msg_wdata;
    if (cr_reset) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end else if (cr_start) begin
      stub_cnt <= 1;
    end else if (stub_cnt != 0 && !stub_done) begin
      if (stub_cnt == 9) stub_done <= 1'b1;
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign cr_done   = stub_done;
  assign cr_digest = {4{ram[0]}};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        f;
    logic        e;
    logic [31:0] m;
    logic [31:0] c;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t mk(input logic f, input logic e, input logic [31:0] m, input logic [31:0] c);
    exp_t x;
    x.f = f; x.e = e; x.m = m; x.c = c;
    return x;
  endfunction

  function automatic logic [31:0] model_word(input int idx, input logic [31:0] c);
    if (idx == 0)  return c;
    if (idx == 1)  return 32'h80;
    if (idx == 14) return 32'd32;
    return 32'h0;
  endfunction

  logic [31:0] exp_cand;
  int          exp_addr;
  int          busy_cycles;
  logic        prev_busy  = 1'b0;
  logic        prev_crr   = 1'b0;

  // Message writes, cruncher handshake and end-of-search scoreboard.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (msg_we === 1'b1) begin
      chk("msg_waddr", msg_waddr, exp_addr[3:0]);
      chk("msg_wdata", msg_wdata, model_word(exp_addr, exp_cand));
      chk("we_while_running", (stub_cnt != 0 && !stub_done), 1'b0);
      if (exp_addr == 15) begin
        exp_addr = 0;
        exp_cand = exp_cand + 32'd1;
      end else begin
        exp_addr++;
      end
    end
    if (cr_start === 1'b1) chk("cr_reset_before_start", prev_crr, 1'b1);
    prev_crr = cr_reset;
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_end", 1'b1, 1'b0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("found", found, x.f);
        chk("exhausted", exhausted, x.e);
        chk("cand_count", cand_count, x.c);
        if (x.f) chk("match_value", match_value, x.m);
      end
    end
    prev_busy = busy;
  end

  task automatic start(input logic [31:0] f, input logic [31:0] l, input logic [127:0] t);
    @(negedge clk);
    cfg_first   = f;
    cfg_last    = l;
    cfg_target  = t;
    cfg_start   = 1'b1;
    exp_cand    = f;
    exp_addr    = 0;
    busy_cycles = 0;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", (n < 3000), 1'b1);
  endtask

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_first = '0; cfg_last = '0; cfg_target = '0;
    exp_cand = '0; exp_addr = 0; busy_cycles = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_found", found, 1'b0);
    chk("rst_exhausted", exhausted, 1'b0);
    chk("rst_msg_we", msg_we, 1'b0);
    chk("rst_cr_start", cr_start, 1'b0);
    chk("rst_match_value", match_value, 32'h0);
    chk("rst_cand_count", cand_count, 32'h0);
    chk("rst_msg_waddr", msg_waddr, 4'h0);
    chk("rst_msg_wdata", msg_wdata, 32'h0);
    chk("rst_cr_reset", cr_reset, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cr_reset", cr_reset, 1'b0);

    // Match inside the range.
    sb.push_back(mk(1'b1, 1'b0, 32'd7, 32'd3));
    start(32'd5, 32'd9, {4{32'h7}});
    chk("busy_rise", busy, 1'b1);
    wait_idle();

    // No match: exhaustion and per-candidate timing.
    sb.push_back(mk(1'b0, 1'b1, 32'd0, 32'd5));
    start(32'd5, 32'd9, {4{32'h100}});
    wait_idle();
    chk("busy_cycles", busy_cycles, 32'd145);

    // Wrap-around through 0xFFFFFFFF.
    sb.push_back(mk(1'b1, 1'b0, 32'd0, 32'd3));
    start(32'hFFFF_FFFE, 32'h1, {4{32'h0}});
    wait_idle();

    // Single-candidate range.
    sb.push_back(mk(1'b0, 1'b1, 32'd0, 32'd1));
    start(32'h1234, 32'h1234, {4{32'h0}});
    wait_idle();

    // Abort during WAIT of the second candidate.
    sb.push_back(mk(1'b0, 1'b0, 32'd0, 32'd1));
    start(32'd0, 32'd9, {4{32'h100}});
    begin
      int n;
      n = 0;
      while (!(cand_count == 32'd1 && stub_cnt == 5) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("abort_reach_wait", (n < 200), 1'b1);
    end
    cfg_abort = 1'b1;
    #1 chk("abort_cr_reset", cr_reset, 1'b1);
    @(negedge clk);
    cfg_abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_cand_count", cand_count, 32'd1);

    // Fresh start after abort runs normally.
    sb.push_back(mk(1'b1, 1'b0, 32'd3, 32'd2));
    start(32'd2, 32'd3, {4{32'h3}});
    wait_idle();

    // Simultaneous start and abort in IDLE: no launch.
    @(negedge clk);
    cfg_first = 32'd1; cfg_last = 32'd2; cfg_target = '0;
    cfg_start = 1'b1; cfg_abort = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("start_abort_busy_late", busy, 1'b0);

    // Start while busy is ignored.
    sb.push_back(mk(1'b1, 1'b0, 32'd7, 32'd3));
    start(32'd5, 32'd9, {4{32'h7}});
    repeat (5) @(negedge clk);
    cfg_first = 32'd100; cfg_last = 32'd200; cfg_target = {4{32'd150}};
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_idle();

    // Reset mid-search.
    sb.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0));
    start(32'd0, 32'd9, {4{32'h100}});
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1 chk("midrst_cr_reset", cr_reset, 1'b1);
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md5_search_ctrl.md
# md5_search_ctrl

Sequencer for one MD5 chunk-cruncher datapath. It walks a 32-bit candidate range and, for each candidate, writes a padded single-block message into the cruncher's message RAM. It then resets and starts the cruncher, waits for completion, and compares the digest against a target. The block sits between the host/config registers and one cruncher plus its 16x32 message RAM. It reports the first matching candidate or range exhaustion.

## Interface
- MSG_LEN_BITS, 32: bit length written to message word 14 (candidate is 4 bytes).
- clk  in  1  clock; reset is synchronous, active-high.
- reset  in  1  clears FSM, flags and counters.
- cfg_start  in  1  pulse; launches a search when sampled in IDLE.
- cfg_abort  in  1  pulse; stops any search; wins over cfg_start.
- cfg_first  in  32  first candidate; latched on accepted cfg_start.
- cfg_last  in  32  last candidate, inclusive; latched on accepted cfg_start.
- cfg_target  in  128  target digest {d,c,b,a}; latched on accepted cfg_start.
- busy  out  1  high in every state except IDLE.
- found  out  1  sticky; last search matched.
- exhausted  out  1  sticky; last search ended without a match.
- match_value  out  32  matching candidate; valid while found=1.
- cand_count  out  32  candidates checked since last accepted start.
- msg_we  out  1  message RAM write enable.
- msg_waddr  out  4  message RAM word address.
- msg_wdata  out  32  message RAM write data.
- cr_reset  out  1  cruncher reset; high while reset is high and during CRST.
- cr_start  out  1  cruncher start pulse.
- cr_done  in  1  cruncher done; level, held until cr_reset.
- cr_digest  in  128  cruncher digest {d,c,b,a}.

## Operation
- States: IDLE, LOAD, CRST, CSTART, WAIT, CHECK.
- IDLE, cfg_start=1 and cfg_abort=0:
  - latch cfg_first into cand, and latch cfg_last and cfg_target.
  - clear found, exhausted, cand_count and word index w.
  - go to LOAD.
- LOAD: msg_we=1, msg_waddr=w. w increments each cycle; after w=15, go to CRST.
- Message words, little-endian MD5 padding for a 4-byte message:
  - word 0 = cand.
  - word 1 = 0x00000080.
  - words 2-13 = 0.
  - word 14 = MSG_LEN_BITS.
  - word 15 = 0.
- CRST: cr_reset=1 for one cycle, then CSTART. The cruncher accumulates its chaining values across runs, so it is reset before every candidate.
- CSTART: cr_start=1 for one cycle, then WAIT.
- WAIT: hold until cr_done=1; on that cycle register cr_digest and go to CHECK. No timeout.
- CHECK: cand_count += 1. Then:
  - if registered digest == target: found=1, match_value=cand, go to IDLE.
  - else if cand == last: exhausted=1, go to IDLE.
  - else: cand = cand+1 (mod 2^32), w=0, go to LOAD.
- Wrap-around: when first > last, the search wraps through 0xFFFFFFFF -> 0 until it reaches last.
- first == last checks exactly one candidate.
- The message RAM is written only in LOAD, never while the cruncher runs.
- cfg_abort in any non-IDLE state:
  - next state is IDLE, and cr_reset=1 on the abort cycle.
  - found and exhausted stay 0; cand_count holds its value.
- cfg_start while busy is ignored.
- cfg_abort in IDLE has no effect, except that it suppresses a simultaneous cfg_start.
- A found match takes precedence over exhaustion when cand == last also matches.

## Timing
- Reset values:
  - state IDLE.
  - busy, found, exhausted, msg_we and cr_start are 0.
  - match_value, cand_count, msg_waddr and msg_wdata are 0.
  - cr_reset is 1 while reset is high.
- All outputs except cr_reset are registered. cr_reset = reset | (state==CRST) | abort_cycle.
- Per candidate: 16 (LOAD) + 1 (CRST) + 1 (CSTART) + W (WAIT, including the cr_done cycle) + 1 (CHECK) cycles.
- busy rises the cycle after an accepted cfg_start. It falls the cycle after CHECK resolves, or the cycle after the abort.
- found/exhausted update in the same edge that busy falls.
- Reset mid-search returns to IDLE immediately; the cruncher is also reset via cr_reset.

## Test plan
- Bench uses a stub cruncher: digest = {4{RAM word 0}}, done asserted N=10 cycles after cr_start, held until cr_reset. It checks cr_reset precedes every cr_start by one cycle.
- Range 5..9, target {4{32'h7}}: found=1, match_value=7, cand_count=3. The LOAD for candidate 6 shows words 0x6, 0x80, 0, ..., 14=0x20, 15=0.
- Range 5..9, target {4{32'h100}}: exhausted=1, found=0, cand_count=5. busy high for exactly 5*29 cycles.
- Wrap: range 0xFFFFFFFE..0x1, target {4{32'h0}}: found=1, match_value=0, cand_count=3.
- Abort during WAIT of the second candidate (range 0..9, no match): IDLE next cycle, cr_reset pulse, found=exhausted=0, cand_count=1. A fresh start then runs normally.
- Simultaneous cfg_start+cfg_abort in IDLE: no start, busy stays 0. cfg_start while busy: range registers unchanged.
